// File: rtl/vec_pkg.sv
// Shared types and geometry helpers for the vector strip-mining sequencer.
package vec_pkg;

  typedef enum logic [1:0] {
    SEW8  = 2'b00,
    SEW16 = 2'b01,
    SEW32 = 2'b10,
    SEW64 = 2'b11
  } sew_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  function automatic int unsigned bpb(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned beats_per_reg(input int unsigned vlen, input int unsigned data_width);
    return vlen / data_width;
  endfunction

  function automatic int unsigned vaddr_bits(input int unsigned vlen, input int unsigned data_width);
    return 5 + $clog2(vlen / data_width);
  endfunction

endpackage

// File: rtl/vec_be_gen.sv
// Last-beat byte-enable mask: low `rem` bytes set, or a full beat when rem is zero.
module vec_be_gen #(
  parameter  int unsigned BPB   = 8,
  localparam int unsigned REM_W = $clog2(BPB)
) (
  input  logic [REM_W-1:0] rem,
  output logic [BPB-1:0]   be_c
);

  always_comb begin
    be_c = '0;
    for (int i = 0; i < int'(BPB); i++) begin
      be_c[i] = (rem == '0) || (i < int'(rem));
    end
  end

endmodule

// File: rtl/vec_strip_seq.sv
// Splits one vector op into DATA_WIDTH-wide register-file beats with ready/valid backpressure.
// Optional perf counters when VEC_STRIP_SEQ_PERF_EN is defined.
module vec_strip_seq
  import vec_pkg::*;
#(
  parameter  int unsigned VLEN          = 16384,
  parameter  int unsigned DATA_WIDTH    = 64,
  parameter  int unsigned VLEN_B_BITS   = 12,
  localparam int unsigned BPB           = bpb(DATA_WIDTH),
  localparam int unsigned BEATS_PER_REG = beats_per_reg(VLEN, DATA_WIDTH),
  localparam int unsigned VADDR_BITS    = vaddr_bits(VLEN, DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [VLEN_B_BITS-1:0] req_vl,
  input  logic [1:0]             req_sew,
  input  logic                   req_vill,
  input  logic [4:0]             req_vd,
  input  logic [4:0]             req_vs1,
  input  logic [4:0]             req_vs2,
  output logic                   beat_valid,
  input  logic                   beat_ready,
  output logic [VADDR_BITS-1:0]  beat_addr_vd,
  output logic [VADDR_BITS-1:0]  beat_addr_vs1,
  output logic [VADDR_BITS-1:0]  beat_addr_vs2,
  output logic [BPB-1:0]         beat_be,
  output logic                   beat_first,
  output logic                   beat_last,
  output logic                   busy,
  output logic                   done
`ifdef VEC_STRIP_SEQ_PERF_EN
  ,
  output logic [31:0]            perf_beats,
  output logic [31:0]            perf_stalls
`endif
);

  localparam int unsigned BPB_LOG = $clog2(BPB);
  localparam int unsigned BPR_LOG = $clog2(BEATS_PER_REG);
  localparam int unsigned TB_W    = VLEN_B_BITS + 3;
  localparam int unsigned CNT_W   = TB_W + 1 - BPB_LOG;

  seq_state_e state_q, state_d;

  logic [CNT_W-1:0]      cnt_q, cnt_d, nlast_q, nlast_d;
  logic [BPB-1:0]        last_be_q, last_be_d;
  logic                  beat_valid_d, beat_first_d, beat_last_d, done_d;
  logic [VADDR_BITS-1:0] addr_vd_d, addr_vs1_d, addr_vs2_d;
  logic [BPB-1:0]        beat_be_d;

  sew_e             sew;
  logic             accept, zero_len, fire, last_next;
  logic [TB_W-1:0]  total_bytes;
  logic [TB_W:0]    round_up;
  logic [CNT_W-1:0] nbeats_m1, cnt_inc;
  logic [BPB-1:0]   last_mask_c;

  assign sew         = sew_e'(req_sew);
  assign accept      = req_valid & req_ready;
  assign zero_len    = req_vill | (req_vl == '0);
  assign fire        = beat_valid & beat_ready;
  assign total_bytes = TB_W'(req_vl) << sew;
  assign round_up    = {1'b0, total_bytes} + (TB_W + 1)'(BPB - 1);
  assign nbeats_m1   = CNT_W'(round_up >> BPB_LOG) - CNT_W'(1);
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign last_next   = (cnt_inc == nlast_q);

  vec_be_gen #(.BPB(BPB)) u_be_gen (
    .rem  (total_bytes[BPB_LOG-1:0]),
    .be_c (last_mask_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !zero_len) state_d = RUN;
      RUN:     if (fire && beat_last)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered beat outputs; hold by default so stalls freeze everything.
  always_comb begin
    cnt_d        = cnt_q;
    nlast_d      = nlast_q;
    last_be_d    = last_be_q;
    beat_valid_d = beat_valid;
    beat_first_d = beat_first;
    beat_last_d  = beat_last;
    beat_be_d    = beat_be;
    addr_vd_d    = beat_addr_vd;
    addr_vs1_d   = beat_addr_vs1;
    addr_vs2_d   = beat_addr_vs2;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && zero_len) begin
          done_d = 1'b1;
        end else if (accept) begin
          cnt_d        = '0;
          nlast_d      = nbeats_m1;
          last_be_d    = last_mask_c;
          beat_valid_d = 1'b1;
          beat_first_d = 1'b1;
          beat_last_d  = (nbeats_m1 == '0);
          beat_be_d    = (nbeats_m1 == '0) ? last_mask_c : {BPB{1'b1}};
          addr_vd_d    = VADDR_BITS'(req_vd)  << BPR_LOG;
          addr_vs1_d   = VADDR_BITS'(req_vs1) << BPR_LOG;
          addr_vs2_d   = VADDR_BITS'(req_vs2) << BPR_LOG;
        end
      end
      RUN: begin
        if (fire && beat_last) begin
          beat_valid_d = 1'b0;
          beat_first_d = 1'b0;
          beat_last_d  = 1'b0;
          beat_be_d    = '0;
          done_d       = 1'b1;
        end else if (fire) begin
          cnt_d        = cnt_inc;
          beat_first_d = 1'b0;
          beat_last_d  = last_next;
          beat_be_d    = last_next ? last_be_q : {BPB{1'b1}};
          addr_vd_d    = beat_addr_vd  + VADDR_BITS'(1);
          addr_vs1_d   = beat_addr_vs1 + VADDR_BITS'(1);
          addr_vs2_d   = beat_addr_vs2 + VADDR_BITS'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      nlast_q       <= '0;
      last_be_q     <= '0;
      beat_valid    <= 1'b0;
      beat_first    <= 1'b0;
      beat_last     <= 1'b0;
      beat_be       <= '0;
      beat_addr_vd  <= '0;
      beat_addr_vs1 <= '0;
      beat_addr_vs2 <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
      req_ready     <= 1'b1;
    end else begin
      cnt_q         <= cnt_d;
      nlast_q       <= nlast_d;
      last_be_q     <= last_be_d;
      beat_valid    <= beat_valid_d;
      beat_first    <= beat_first_d;
      beat_last     <= beat_last_d;
      beat_be       <= beat_be_d;
      beat_addr_vd  <= addr_vd_d;
      beat_addr_vs1 <= addr_vs1_d;
      beat_addr_vs2 <= addr_vs2_d;
      done          <= done_d;
      busy          <= (state_d == RUN);
      req_ready     <= (state_d == IDLE);
    end
  end

`ifdef VEC_STRIP_SEQ_PERF_EN
  // Saturating handshake and stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_beats  <= '0;
      perf_stalls <= '0;
    end else begin
      if (fire && !(&perf_beats))                      perf_beats  <= perf_beats + 32'd1;
      if (beat_valid && !beat_ready && !(&perf_stalls)) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vec_strip_seq.sv
// Directed self-checking bench for vec_strip_seq with hand-computed beat expectations.
module tb_vec_strip_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_vl;
  logic [1:0]  req_sew;
  logic        req_vill;
  logic [4:0]  req_vd, req_vs1, req_vs2;
  logic        beat_valid;
  logic        beat_ready;
  logic [12:0] beat_addr_vd, beat_addr_vs1, beat_addr_vs2;
  logic [7:0]  beat_be;
  logic        beat_first, beat_last;
  logic        busy, done;
`ifdef VEC_STRIP_SEQ_PERF_EN
  logic [31:0] perf_beats, perf_stalls;
`endif

  int n_vec = 0;
  int n_err = 0;

  vec_strip_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_vl        (req_vl),
    .req_sew       (req_sew),
    .req_vill      (req_vill),
    .req_vd        (req_vd),
    .req_vs1       (req_vs1),
    .req_vs2       (req_vs2),
    .beat_valid    (beat_valid),
    .beat_ready    (beat_ready),
    .beat_addr_vd  (beat_addr_vd),
    .beat_addr_vs1 (beat_addr_vs1),
    .beat_addr_vs2 (beat_addr_vs2),
    .beat_be       (beat_be),
    .beat_first    (beat_first),
    .beat_last     (beat_last),
    .busy          (busy),
    .done          (done)
`ifdef VEC_STRIP_SEQ_PERF_EN
    ,
    .perf_beats    (perf_beats),
    .perf_stalls   (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single accepted cycle; returns sampled just after the accept edge.
  task automatic issue(input logic [11:0] vl, input logic [1:0] sew, input logic vill,
                       input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2);
    int waited = 0;
    while (!req_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!req_ready) check("issue_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_vl    = vl;
    req_sew   = sew;
    req_vill  = vill;
    req_vd    = vd;
    req_vs1   = vs1;
    req_vs2   = vs2;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic single_beat_scenario(input string pfx);
    issue(12'd5, 2'b00, 1'b0, 5'd2, 5'd4, 5'd6);
    check({pfx, "_valid"}, 32'(beat_valid), 32'd1);
    check({pfx, "_vd"},    32'(beat_addr_vd), 32'd512);
    check({pfx, "_vs1"},   32'(beat_addr_vs1), 32'd1024);
    check({pfx, "_vs2"},   32'(beat_addr_vs2), 32'd1536);
    check({pfx, "_be"},    32'(beat_be), 32'h1F);
    check({pfx, "_first"}, 32'(beat_first), 32'd1);
    check({pfx, "_last"},  32'(beat_last), 32'd1);
    check({pfx, "_busy"},  32'(busy), 32'd1);
    check({pfx, "_rdy"},   32'(req_ready), 32'd0);
    tick();
    check({pfx, "_done"},  32'(done), 32'd1);
    check({pfx, "_vdrop"}, 32'(beat_valid), 32'd0);
    check({pfx, "_idle"},  32'(req_ready), 32'd1);
    tick();
    check({pfx, "_done1"}, 32'(done), 32'd0);
  endtask

  initial begin
    int          n, bad_be, n_first, n_last;
    logic [12:0] last_vd, last_vs1, last_vs2;
    logic [7:0]  exp_be;

    rst_n = 1'b0; req_valid = 1'b0; req_vl = '0; req_sew = '0; req_vill = 1'b0;
    req_vd = '0; req_vs1 = '0; req_vs2 = '0; beat_ready = 1'b1;
    #12;
    check("rst_valid", 32'(beat_valid), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_be",    32'(beat_be), 32'd0);
    check("rst_vd",    32'(beat_addr_vd), 32'd0);
    #3 rst_n = 1'b1;
    tick();

    // 34-byte op, stall 3 cycles on beat 2 while a second request is ignored.
    issue(12'd17, 2'b01, 1'b0, 5'd3, 5'd0, 5'd31);
    for (int i = 0; i < 5; i++) begin
      exp_be = (i == 4) ? 8'h03 : 8'hFF;
      check($sformatf("s2_vd%0d", i),    32'(beat_addr_vd), 32'(768 + i));
      check($sformatf("s2_vs2_%0d", i),  32'(beat_addr_vs2), 32'(7936 + i));
      check($sformatf("s2_be%0d", i),    32'(beat_be), 32'(exp_be));
      check($sformatf("s2_first%0d", i), 32'(beat_first), 32'(i == 0));
      check($sformatf("s2_last%0d", i),  32'(beat_last), 32'(i == 4));
      if (i == 2) begin
        beat_ready = 1'b0;
        req_valid = 1'b1; req_vl = 12'd1; req_vd = 5'd9;
        for (int s = 0; s < 3; s++) begin
          tick();
          check($sformatf("s2_hold_vd%0d", s),    32'(beat_addr_vd), 32'd770);
          check($sformatf("s2_hold_be%0d", s),    32'(beat_be), 32'hFF);
          check($sformatf("s2_hold_valid%0d", s), 32'(beat_valid), 32'd1);
          check($sformatf("s2_hold_last%0d", s),  32'(beat_last), 32'd0);
        end
        req_valid = 1'b0;
        beat_ready = 1'b1;
      end
      tick();
    end
    check("s2_done",  32'(done), 32'd1);
    check("s2_valid", 32'(beat_valid), 32'd0);
`ifdef VEC_STRIP_SEQ_PERF_EN
    check("s2_perf_beats",  perf_beats, 32'd5);
    check("s2_perf_stalls", perf_stalls, 32'd3);
`endif
    tick();
    check("s2_no_queue_valid", 32'(beat_valid), 32'd0);
    check("s2_no_queue_busy",  32'(busy), 32'd0);

    single_beat_scenario("s1");

    // Full-register op at SEW64, vs2 wraps past v31.
    issue(12'd2048, 2'b11, 1'b0, 5'd8, 5'd9, 5'd31);
    n = 0; bad_be = 0; n_first = 0; n_last = 0;
    last_vd = '0; last_vs1 = '0; last_vs2 = '0;
    while (beat_valid && n < 3000) begin
      if (beat_be != 8'hFF) bad_be++;
      if (beat_first) n_first++;
      if (beat_last) begin
        n_last++;
        last_vd = beat_addr_vd; last_vs1 = beat_addr_vs1; last_vs2 = beat_addr_vs2;
      end
      n++;
      tick();
    end
    check("s3_beats",   32'(n), 32'd2048);
    check("s3_bad_be",  32'(bad_be), 32'd0);
    check("s3_firsts",  32'(n_first), 32'd1);
    check("s3_lasts",   32'(n_last), 32'd1);
    check("s3_last_vd", 32'(last_vd), 32'd4095);
    check("s3_last_vs1", 32'(last_vs1), 32'd4351);
    check("s3_last_vs2", 32'(last_vs2), 32'd1791);
    check("s3_done",    32'(done), 32'd1);

    // Zero-length and illegal-vtype ops complete without beats.
    issue(12'd0, 2'b00, 1'b0, 5'd1, 5'd1, 5'd1);
    check("s4_vl0_done",  32'(done), 32'd1);
    check("s4_vl0_valid", 32'(beat_valid), 32'd0);
    check("s4_vl0_ready", 32'(req_ready), 32'd1);
    tick();
    check("s4_vl0_done1", 32'(done), 32'd0);
    issue(12'd8, 2'b00, 1'b1, 5'd1, 5'd1, 5'd1);
    check("s4_vill_done",  32'(done), 32'd1);
    check("s4_vill_valid", 32'(beat_valid), 32'd0);
    check("s4_vill_ready", 32'(req_ready), 32'd1);
    tick();
    check("s4_vill_done1", 32'(done), 32'd0);
    check("s4_vill_busy",  32'(busy), 32'd0);

    // Reset at beat index 2 of a 5-beat op.
    issue(12'd17, 2'b01, 1'b0, 5'd1, 5'd1, 5'd1);
    tick();
    tick();
    check("s6_pre_vd", 32'(beat_addr_vd), 32'd258);
    rst_n = 1'b0;
    #1;
    check("s6_valid", 32'(beat_valid), 32'd0);
    check("s6_busy",  32'(busy), 32'd0);
    check("s6_be",    32'(beat_be), 32'd0);
    check("s6_vd",    32'(beat_addr_vd), 32'd0);
    check("s6_first", 32'(beat_first), 32'd0);
    check("s6_last",  32'(beat_last), 32'd0);
    check("s6_ready", 32'(req_ready), 32'd1);
    #10 rst_n = 1'b1;
    tick();
    check("s6_no_done", 32'(done), 32'd0);
    single_beat_scenario("s6r");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
